// File: rtl/reg_wb_pkg.sv
// Shared definitions for the register-file writeback controller: the pipeline
// entry layout, architectural register constants and the op-class encoding
// produced by the destination decoder.
package reg_wb_pkg;

    // Default register address width of the MIPS register file.
    localparam int DEF_ADDR_W = 5;

    // $0 is hard-wired; writes to it are dropped and it never creates a hazard.
    localparam int ZERO_REG = 0;

    // Default destination for jump-and-link instructions ($ra).
    localparam int LINK_REG_DEF = 31;

    // Op class chosen by the destination decoder (priority link > mem > alu).
    localparam logic [1:0] OP_NONE = 2'd0;
    localparam logic [1:0] OP_ALU  = 2'd1;
    localparam logic [1:0] OP_MEM  = 2'd2;
    localparam logic [1:0] OP_LINK = 2'd3;

    // One in-flight writeback entry at the default address width.
    typedef struct packed {
        logic                  valid;
        logic [DEF_ADDR_W-1:0] addr;
    } wb_entry_t;

endpackage

// File: rtl/reg_wb_decode.sv
// Destination decoder: turns the op flags and rt/rd fields of one instruction
// into a {write enable, write address} pair. Writes to $0 are suppressed here
// so every consumer (stage array, hazard logic) sees them as non-writing.
module reg_wb_decode
    import reg_wb_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int LINK_REG = LINK_REG_DEF
) (
    input  logic              alu_op,
    input  logic              mem_op,
    input  logic              write_op,
    input  logic              link_op,
    input  logic [ADDR_W-1:0] rt_addr,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              en,
    output logic [ADDR_W-1:0] addr
);

    logic [1:0]        op_sel_s;
    logic              raw_en_s;
    logic [ADDR_W-1:0] raw_addr_s;

    // Resolve overlapping op flags to a single class, link first.
    always_comb begin
        op_sel_s = OP_NONE;
        if (link_op) begin
            op_sel_s = OP_LINK;
        end else if (mem_op) begin
            op_sel_s = OP_MEM;
        end else if (alu_op) begin
            op_sel_s = OP_ALU;
        end else begin
            op_sel_s = OP_NONE;
        end
    end

    // Map the op class to a destination; stores keep rt but do not write.
    always_comb begin
        raw_en_s   = 1'b0;
        raw_addr_s = ADDR_W'(ZERO_REG);
        case (op_sel_s)
            OP_LINK: begin
                raw_en_s   = 1'b1;
                raw_addr_s = ADDR_W'(LINK_REG);
            end
            OP_MEM: begin
                raw_en_s   = ~write_op;
                raw_addr_s = rt_addr;
            end
            OP_ALU: begin
                raw_en_s   = 1'b1;
                raw_addr_s = rd_addr;
            end
            default: begin
                raw_en_s   = 1'b0;
                raw_addr_s = ADDR_W'(ZERO_REG);
            end
        endcase
    end

    assign en   = raw_en_s & (raw_addr_s != ADDR_W'(ZERO_REG));
    assign addr = raw_addr_s;

endmodule

// File: rtl/reg_file_wb_ctrlr.sv
// Pipelined register-file writeback controller. Each accepted instruction's
// decoded destination travels through PIPE_DEPTH stages; the last stage
// drives the register-file write port directly. Stall freezes stages
// 1..D-1 and drains the writeback stage with a bubble so nothing writes twice.
// Flush kills entries in stages 1..D-2 while letting s[D-1] retire.
module reg_file_wb_ctrlr
    import reg_wb_pkg::*;
#(
    parameter int PIPE_DEPTH = 3,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int LINK_REG   = LINK_REG_DEF,
    parameter int WB_BYPASS  = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              w_issue_valid,
    input  logic              w_alu_op,
    input  logic              w_mem_op,
    input  logic              w_write_op,
    input  logic              w_link_op,
    input  logic [ADDR_W-1:0] w_rt_addr,
    input  logic [ADDR_W-1:0] w_rd_addr,
    input  logic              w_stall,
    input  logic              w_flush,
    input  logic [ADDR_W-1:0] w_src_a_addr,
    input  logic [ADDR_W-1:0] w_src_b_addr,
    output logic              w_en_out,
    output logic [ADDR_W-1:0] w_waddr_out,
    output logic              w_hazard_a_out,
    output logic              w_hazard_b_out
);

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
    } stage_t;

    localparam stage_t BUBBLE = stage_t'({1'b0, {ADDR_W{1'b0}}});

    // Last stage included in hazard checks: the writeback stage is skipped
    // when the register file forwards same-cycle writes.
    localparam int HZ_LAST = (WB_BYPASS != 0) ? PIPE_DEPTH - 1 : PIPE_DEPTH;

    // Last stage whose entry a flush kills; s[D-1] always retires.
    localparam int KILL_LAST = PIPE_DEPTH - 2;

    // Whether s[1] itself is a killable stage (false only for D=2).
    localparam bit FLUSH_S1 = (KILL_LAST >= 1);

    logic              dec_en_s;
    logic [ADDR_W-1:0] dec_addr_s;
    logic              accept_s;
    logic              hazard_a_s;
    logic              hazard_b_s;
    stage_t            stage_s [1:PIPE_DEPTH];

    reg_wb_decode #(
        .ADDR_W   (ADDR_W),
        .LINK_REG (LINK_REG)
    ) u_decode (
        .alu_op   (w_alu_op),
        .mem_op   (w_mem_op),
        .write_op (w_write_op),
        .link_op  (w_link_op),
        .rt_addr  (w_rt_addr),
        .rd_addr  (w_rd_addr),
        .en       (dec_en_s),
        .addr     (dec_addr_s)
    );

    assign accept_s = w_issue_valid & ~w_stall & ~w_flush;

    for (genvar k = 1; k <= PIPE_DEPTH; k++) begin : g_stage
        stage_t entry_r;
        assign stage_s[k] = entry_r;

        if (k == 1) begin : g_first
            // Issue stage: load the decoded destination, hold on stall, else bubble.
            always_ff @(posedge clock) begin
                if (reset) begin
                    entry_r <= BUBBLE;
                end else if (w_stall) begin
                    if (w_flush && FLUSH_S1) begin
                        entry_r <= BUBBLE;
                    end else begin
                        entry_r <= entry_r;
                    end
                end else if (accept_s) begin
                    entry_r <= stage_t'({dec_en_s, dec_addr_s});
                end else begin
                    entry_r <= BUBBLE;
                end
            end
        end else if (k == PIPE_DEPTH) begin : g_last
            // Writeback stage: take s[D-1] or drain with a bubble while stalled.
            always_ff @(posedge clock) begin
                if (reset) begin
                    entry_r <= BUBBLE;
                end else if (w_stall) begin
                    entry_r <= BUBBLE;
                end else begin
                    entry_r <= stage_s[k-1];
                end
            end
        end else begin : g_mid
            // Middle stage: hold on stall, advance otherwise; flush kills young entries.
            always_ff @(posedge clock) begin
                if (reset) begin
                    entry_r <= BUBBLE;
                end else if (w_stall) begin
                    if (w_flush && (k <= KILL_LAST)) begin
                        entry_r <= BUBBLE;
                    end else begin
                        entry_r <= entry_r;
                    end
                end else if (w_flush) begin
                    entry_r <= BUBBLE;
                end else begin
                    entry_r <= stage_s[k-1];
                end
            end
        end
    end

    // Raise a hazard when a valid in-flight entry targets a non-zero source.
    always_comb begin
        hazard_a_s = 1'b0;
        hazard_b_s = 1'b0;
        for (int k = 1; k <= HZ_LAST; k++) begin
            if (stage_s[k].valid && (stage_s[k].addr == w_src_a_addr)) begin
                hazard_a_s = 1'b1;
            end else begin
                hazard_a_s = hazard_a_s;
            end
            if (stage_s[k].valid && (stage_s[k].addr == w_src_b_addr)) begin
                hazard_b_s = 1'b1;
            end else begin
                hazard_b_s = hazard_b_s;
            end
        end
    end

    assign w_hazard_a_out = hazard_a_s & (w_src_a_addr != ADDR_W'(ZERO_REG));
    assign w_hazard_b_out = hazard_b_s & (w_src_b_addr != ADDR_W'(ZERO_REG));
    assign w_en_out       = stage_s[PIPE_DEPTH].valid;
    assign w_waddr_out    = stage_s[PIPE_DEPTH].addr;

endmodule

// File: tb/tb_reg_file_wb_ctrlr.sv
// Directed bench for reg_file_wb_ctrlr. Three instances share one stimulus:
//   a: D=3, WB_BYPASS=1   b: D=4, WB_BYPASS=1   c: D=3, WB_BYPASS=0
// Expected values are hand-derived per scenario.
module tb_reg_file_wb_ctrlr;

    logic       clock;
    logic       reset;
    logic       w_issue_valid;
    logic       w_alu_op;
    logic       w_mem_op;
    logic       w_write_op;
    logic       w_link_op;
    logic [4:0] w_rt_addr;
    logic [4:0] w_rd_addr;
    logic       w_stall;
    logic       w_flush;
    logic [4:0] w_src_a_addr;
    logic [4:0] w_src_b_addr;

    logic       a_en, b_en, c_en;
    logic [4:0] a_waddr, b_waddr, c_waddr;
    logic       a_hza, a_hzb, b_hza, b_hzb, c_hza, c_hzb;

    int checks = 0;
    int errors = 0;

    reg_file_wb_ctrlr #(.PIPE_DEPTH(3), .ADDR_W(5), .LINK_REG(31), .WB_BYPASS(1)) dut_a (
        .clock(clock), .reset(reset), .w_issue_valid(w_issue_valid),
        .w_alu_op(w_alu_op), .w_mem_op(w_mem_op), .w_write_op(w_write_op),
        .w_link_op(w_link_op), .w_rt_addr(w_rt_addr), .w_rd_addr(w_rd_addr),
        .w_stall(w_stall), .w_flush(w_flush),
        .w_src_a_addr(w_src_a_addr), .w_src_b_addr(w_src_b_addr),
        .w_en_out(a_en), .w_waddr_out(a_waddr),
        .w_hazard_a_out(a_hza), .w_hazard_b_out(a_hzb)
    );

    reg_file_wb_ctrlr #(.PIPE_DEPTH(4), .ADDR_W(5), .LINK_REG(31), .WB_BYPASS(1)) dut_b (
        .clock(clock), .reset(reset), .w_issue_valid(w_issue_valid),
        .w_alu_op(w_alu_op), .w_mem_op(w_mem_op), .w_write_op(w_write_op),
        .w_link_op(w_link_op), .w_rt_addr(w_rt_addr), .w_rd_addr(w_rd_addr),
        .w_stall(w_stall), .w_flush(w_flush),
        .w_src_a_addr(w_src_a_addr), .w_src_b_addr(w_src_b_addr),
        .w_en_out(b_en), .w_waddr_out(b_waddr),
        .w_hazard_a_out(b_hza), .w_hazard_b_out(b_hzb)
    );

    reg_file_wb_ctrlr #(.PIPE_DEPTH(3), .ADDR_W(5), .LINK_REG(31), .WB_BYPASS(0)) dut_c (
        .clock(clock), .reset(reset), .w_issue_valid(w_issue_valid),
        .w_alu_op(w_alu_op), .w_mem_op(w_mem_op), .w_write_op(w_write_op),
        .w_link_op(w_link_op), .w_rt_addr(w_rt_addr), .w_rd_addr(w_rd_addr),
        .w_stall(w_stall), .w_flush(w_flush),
        .w_src_a_addr(w_src_a_addr), .w_src_b_addr(w_src_b_addr),
        .w_en_out(c_en), .w_waddr_out(c_waddr),
        .w_hazard_a_out(c_hza), .w_hazard_b_out(c_hzb)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle away from it.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic alu, input logic mem, input logic wr,
                         input logic link, input logic [4:0] rt, input logic [4:0] rd);
        w_issue_valid = 1'b1;
        w_alu_op      = alu;
        w_mem_op      = mem;
        w_write_op    = wr;
        w_link_op     = link;
        w_rt_addr     = rt;
        w_rd_addr     = rd;
    endtask

    task automatic idle();
        w_issue_valid = 1'b0;
        w_alu_op      = 1'b0;
        w_mem_op      = 1'b0;
        w_write_op    = 1'b0;
        w_link_op     = 1'b0;
        w_rt_addr     = 5'd0;
        w_rd_addr     = 5'd0;
    endtask

    task automatic drain();
        idle();
        w_stall = 1'b0;
        w_flush = 1'b0;
        for (int i = 0; i < 5; i++) step();
    endtask

    initial begin
        // Reset with every input active.
        reset        = 1'b1;
        issue(1'b1, 1'b1, 1'b0, 1'b1, 5'd3, 5'd7);
        w_stall      = 1'b1;
        w_flush      = 1'b1;
        w_src_a_addr = 5'd31;
        w_src_b_addr = 5'd7;
        #2;
        step();
        check("rst_a_en",  {31'd0, a_en},  32'd0);
        check("rst_a_hza", {31'd0, a_hza}, 32'd0);
        check("rst_a_hzb", {31'd0, a_hzb}, 32'd0);
        check("rst_c_hzb", {31'd0, c_hzb}, 32'd0);
        check("rst_b_en",  {31'd0, b_en},  32'd0);
        step();
        check("rst2_a_en",    {31'd0, a_en},    32'd0);
        check("rst2_a_waddr", {27'd0, a_waddr}, 32'd0);
        reset   = 1'b0;
        w_stall = 1'b0;
        w_flush = 1'b0;
        idle();
        step();
        check("post_rst_a_en",  {31'd0, a_en},  32'd0);
        check("post_rst_a_hza", {31'd0, a_hza}, 32'd0);
        check("post_rst_a_hzb", {31'd0, a_hzb}, 32'd0);

        // D=3: alu rd=7, load rt=9, store rt=12.
        w_src_a_addr = 5'd7;
        w_src_b_addr = 5'd7;
        issue(1'b1, 1'b0, 1'b0, 1'b0, 5'd2, 5'd7);
        step();
        check("seq_hza_e0", {31'd0, a_hza}, 32'd1);
        issue(1'b0, 1'b1, 1'b0, 1'b0, 5'd9, 5'd3);
        step();
        issue(1'b0, 1'b1, 1'b1, 1'b0, 5'd12, 5'd4);
        step();
        check("seq_en_e2",    {31'd0, a_en},    32'd1);
        check("seq_waddr_e2", {27'd0, a_waddr}, 32'd7);
        check("byp1_hzb_e2",  {31'd0, a_hzb},   32'd0);
        check("byp0_hzb_e2",  {31'd0, c_hzb},   32'd1);
        check("byp0_en_e2",   {31'd0, c_en},    32'd1);
        idle();
        step();
        check("seq_en_e3",    {31'd0, a_en},    32'd1);
        check("seq_waddr_e3", {27'd0, a_waddr}, 32'd9);
        check("byp0_hzb_e3",  {31'd0, c_hzb},   32'd0);
        step();
        check("seq_en_e4",    {31'd0, a_en},    32'd0);

        // Link beats mem/alu; alu to $0 never writes nor flags.
        drain();
        w_src_a_addr = 5'd31;
        issue(1'b1, 1'b1, 1'b0, 1'b1, 5'd6, 5'd5);
        step();
        check("link_hza", {31'd0, a_hza}, 32'd1);
        idle();
        step();
        step();
        check("link_en",    {31'd0, a_en},    32'd1);
        check("link_waddr", {27'd0, a_waddr}, 32'd31);
        w_src_a_addr = 5'd0;
        issue(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
        step();
        check("zero_en_e0",  {31'd0, a_en},  32'd0);
        check("zero_hza_e0", {31'd0, a_hza}, 32'd0);
        idle();
        step();
        step();
        check("zero_en_wb", {31'd0, a_en}, 32'd0);

        // Stall 2 cycles behind alu rd=4: one pulse, 2 cycles late.
        drain();
        w_src_a_addr = 5'd4;
        issue(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd4);
        step();
        check("stall_hza_f0", {31'd0, a_hza}, 32'd1);
        idle();
        w_stall = 1'b1;
        step();
        check("stall_en_f1",  {31'd0, a_en},  32'd0);
        check("stall_hza_f1", {31'd0, a_hza}, 32'd1);
        step();
        check("stall_en_f2",  {31'd0, a_en},  32'd0);
        check("stall_hza_f2", {31'd0, a_hza}, 32'd1);
        w_stall = 1'b0;
        step();
        check("stall_en_f3",  {31'd0, a_en},  32'd0);
        check("stall_hza_f3", {31'd0, a_hza}, 32'd1);
        step();
        check("stall_en_f4",    {31'd0, a_en},    32'd1);
        check("stall_waddr_f4", {27'd0, a_waddr}, 32'd4);
        check("stall_byp1_hza", {31'd0, a_hza},   32'd0);
        check("stall_byp0_hza", {31'd0, c_hza},   32'd1);
        step();
        check("stall_en_f5", {31'd0, a_en}, 32'd0);

        // D=4: rd=1,2,3 in flight, flush with issue rd=6.
        drain();
        issue(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd1);
        step();
        issue(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd2);
        step();
        issue(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd3);
        step();
        check("flush_en_pre", {31'd0, b_en}, 32'd0);
        w_src_a_addr = 5'd2;
        w_src_b_addr = 5'd6;
        w_flush = 1'b1;
        issue(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd6);
        step();
        check("flush_en_g3",    {31'd0, b_en},    32'd1);
        check("flush_waddr_g3", {27'd0, b_waddr}, 32'd1);
        check("flush_hza_g3",   {31'd0, b_hza},   32'd0);
        check("flush_hzb_g3",   {31'd0, b_hzb},   32'd0);
        w_flush = 1'b0;
        idle();
        for (int i = 0; i < 3; i++) begin
            step();
            check("flush_en_after", {31'd0, b_en}, 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
